reg_req_bridge: RTL

Upstream master for the register-slave front end: accepts single-DWORD memory read/write requests from the PCIe target request path over a valid/ready handshake and drives the register bus (registerSelect/registerRead/registerAddress/registerWriteData) into the register slave. It holds select until the slave's one-cycle ack, then returns read data and status to the completion generator. Writes are posted; reads produce exactly one completion. A timeout guarantees forward progress when no ack arrives.

---
 rtl/reg_bridge_pkg.sv | 19 +
 rtl/reg_bridge_timer.sv | 28 ++
 rtl/reg_req_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_bridge_pkg.sv
// Shared types and constants for the register request bridge.
// States, completion status codes and parameter defaults.
package reg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    GAP
  } state_t;

  localparam logic [1:0] CPL_OK      = 2'b00;
  localparam logic [1:0] CPL_DECERR  = 2'b01;
  localparam logic [1:0] CPL_TIMEOUT = 2'b10;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int GAP_DEFAULT     = 2;

endpackage

// File: rtl/reg_bridge_timer.sv
// Loadable up-counter with a terminal-count flag.
// Shared between the ISSUE timeout and the GAP hold-off.
module reg_bridge_timer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/reg_req_bridge.sv
// Request-to-register-bus bridge: one DWORD per transaction,
// posted writes, one completion per read, timeout on missing ack.
module reg_req_bridge
  import reg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int GAP_CYCLES     = GAP_DEFAULT,
  parameter int TAG_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqWrite,
  input  logic [29:0]      reqAddr,
  input  logic [31:0]      reqData,
  input  logic [TAG_W-1:0] reqTag,
  output logic             registerSelect,
  output logic             registerRead,
  output logic [29:0]      registerAddress,
  output logic [31:0]      registerWriteData,
  input  logic             registerAck,
  input  logic             registerError,
  input  logic [31:0]      registerReadData,
  output logic             cplValid,
  input  logic             cplReady,
  output logic [31:0]      cplData,
  output logic [TAG_W-1:0] cplTag,
  output logic [1:0]       cplStatus,
  output logic [15:0]      writeErrCount
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  state_t        state;
  state_t        nxt;
  logic          wr;
  logic          take;
  logic          acked;
  logic          expired;
  logic          fail_wr;
  logic          t_load;
  logic          t_step;
  logic          t_done;
  logic [TW-1:0] t_limit;

  assign take    = reqValid & reqReady;
  assign fail_wr = wr & ((acked & registerError) | expired);

  reg_bridge_timer #(
    .W(TW)
  ) timer (
    .clock(clock),
    .reset(reset),
    .load (t_load),
    .step (t_step),
    .limit(t_limit),
    .done (t_done)
  );

  always_comb begin
    nxt     = state;
    t_load  = 1'b0;
    t_step  = 1'b0;
    t_limit = TO_LAST;
    acked   = 1'b0;
    expired = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          nxt    = ISSUE;
          t_load = 1'b1;
        end
      end
      ISSUE: begin
        t_step = 1'b1;
        acked  = registerAck;
        // an ack on the terminal cycle beats the timeout
        expired = !registerAck & t_done;
        if (acked | expired) begin
          nxt    = wr ? GAP : RESP;
          t_load = 1'b1;
        end
      end
      RESP: begin
        if (cplValid & cplReady) begin
          nxt    = GAP;
          t_load = 1'b1;
        end
      end
      GAP: begin
        t_step  = 1'b1;
        t_limit = GAP_LAST;
        if (t_done) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr                <= 1'b0;
      reqReady          <= 1'b0;
      registerSelect    <= 1'b0;
      registerRead      <= 1'b0;
      registerAddress   <= '0;
      registerWriteData <= '0;
      cplValid          <= 1'b0;
      cplData           <= '0;
      cplTag            <= '0;
      cplStatus         <= CPL_OK;
      writeErrCount     <= '0;
    end else begin
      reqReady       <= (nxt == IDLE);
      registerSelect <= (nxt == ISSUE);
      cplValid       <= (nxt == RESP);
      if (take) begin
        wr                <= reqWrite;
        registerRead      <= !reqWrite;
        registerAddress   <= reqAddr;
        registerWriteData <= reqData;
        cplTag            <= reqTag;
      end else if (nxt != ISSUE) begin
        registerRead <= 1'b0;
      end
      if (acked & !wr) begin
        cplData   <= registerReadData;
        cplStatus <= registerError ? CPL_DECERR : CPL_OK;
      end else if (expired & !wr) begin
        cplData   <= '0;
        cplStatus <= CPL_TIMEOUT;
      end
      if (fail_wr && writeErrCount != 16'hFFFF) begin
        writeErrCount <= writeErrCount + 1'b1;
      end
    end
  end

endmodule
